priority_encoder_seq: RTL

PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

---
 rtl/priority_encoder_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder with a pending register and a valid/ready grant.
// The lowest-numbered pending line is granted; the line is cleared as it is granted.
module priority_encoder_seq #(
  parameter int N_REQ     = 32,
  parameter int IDX_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_bits,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_REQ-1:0]     pending_bits,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     pending_q, pending_d;
  logic [N_REQ-1:0]     grant_clr;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 any_pend;
  logic                 take;
  logic                 ovf_hit;

  // Lowest-numbered set bit of the registered pending value.
  always_comb begin
    sel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_WIDTH'(i);
    end
  end

  assign any_pend = |pending_q;

  // Grant FSM: a new grant is taken in IDLE or when HOLD is accepted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    grant_clr = '0;
    take      = (state_q == IDLE) || out_ready;
    if (take) begin
      if (any_pend) begin
        state_d   = HOLD;
        idx_d     = sel_idx;
        valid_d   = 1'b1;
        grant_clr = ONE << sel_idx;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end
  end

  // Pending update with set-wins collision and sticky overflow.
  always_comb begin
    pending_d = (pending_q & ~grant_clr) | req_bits;
    ovf_hit   = |(req_bits & pending_q & ~grant_clr);
    ovf_d     = ovf_q;
    if (ovf_hit) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_index    = idx_q;
  assign out_valid    = valid_q;
  assign pending_bits = pending_q;
  assign ovf          = ovf_q;

endmodule
